// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end with prefetch queue
//
// Owns the fetch PC and issues in-order pipelined reads on a valid/ready
// memory port whose response latency varies. Returned words are stored with
// their PC in a DEPTH-entry queue that decode drains via valid/ready.
// A redirect flushes the queue and restarts fetch. Requests still in flight
// at that point are marked stale, and their responses are discarded.
//
// Parameters:
//   XLEN      address / PC width
//   RESET_PC  fetch PC after reset (word aligned)
//   DEPTH     queue entries = in-flight + buffered limit (power of 2, >= 2)
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   mem_req_valid_o  read request valid
//   mem_req_ready_i  memory accepts the request this cycle
//   mem_req_addr_o   read address (current fetch PC)
//   mem_rsp_valid_i  read data valid, one per accepted request, in order
//   mem_rsp_data_i   read data
//   redirect_i       flush and restart fetch at redirect_pc_i
//   redirect_pc_i    new fetch PC, bits [1:0] forced to zero
//   insn_valid_o     queue head valid
//   insn_ready_i     consumer takes the queue head
//   insn_o           queue head instruction word
//   insn_pc_o        PC of the queue head

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [31:0]     mem_rsp_data_i,

    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,

    output logic            insn_valid_o,
    input  logic            insn_ready_i,
    output logic [31:0]     insn_o,
    output logic [XLEN-1:0] insn_pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fpc_q;
    logic            started_q;
    logic [PW-1:0]   pending_q;   // accepted requests whose response is outstanding
    logic [PW-1:0]   drop_q;      // oldest pending responses that are stale
    logic [PW-1:0]   rd_ptr_q;    // queue head
    logic [PW-1:0]   wr_ptr_q;    // next slot to receive data
    logic [PW-1:0]   iss_ptr_q;   // next slot to reserve for a live request

    logic [31:0]     data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];

    // ------------------------------------------------------------------
    // Handshakes and derived values
    // ------------------------------------------------------------------
    logic [PW-1:0]   count;
    logic [PW:0]     credit_used;
    logic            req_accept;
    logic            rsp_ok;
    logic            rsp_drop;
    logic            rsp_push;
    logic            pop;
    logic [PW-1:0]   pending_nxt;

    assign count       = wr_ptr_q - rd_ptr_q;

    // Stale in-flight requests still hold credit. This keeps the queue from
    // overflowing when a redirect restarts fetch with responses still outstanding.
    assign credit_used = {1'b0, pending_q} + {1'b0, count};

    assign mem_req_valid_o = started_q && (credit_used < (PW+1)'(DEPTH));
    assign mem_req_addr_o  = fpc_q;

    assign req_accept  = mem_req_valid_o && mem_req_ready_i;

    // A response with nothing pending breaks the protocol and is ignored.
    assign rsp_ok      = mem_rsp_valid_i && (pending_q != '0);
    assign rsp_drop    = rsp_ok && (drop_q != '0);
    assign rsp_push    = rsp_ok && (drop_q == '0) && !redirect_i;

    assign pop         = insn_valid_o && insn_ready_i;

    assign pending_nxt = pending_q + PW'(req_accept) - PW'(rsp_ok);

    assign insn_valid_o = (count != '0);
    assign insn_o       = data_q[rd_ptr_q[AW-1:0]];
    assign insn_pc_o    = pc_q[rd_ptr_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpc_q     <= RESET_PC;
            started_q <= 1'b0;
            pending_q <= '0;
            drop_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            iss_ptr_q <= '0;
        end else begin
            started_q <= 1'b1;
            pending_q <= pending_nxt;
            if (redirect_i) begin
                // Everything still outstanding after this cycle is stale.
                // That includes any request accepted this cycle. A response
                // arriving this cycle is discarded. A pop this cycle has
                // already completed its handshake, so it is not undone.
                fpc_q    <= redirect_pc_i & ~XLEN'(3);
                drop_q   <= pending_nxt;
                // Restart the queue empty. Stale requests do not reserve
                // slots, so all three pointers can meet at any common value.
                rd_ptr_q <= iss_ptr_q;
                wr_ptr_q <= iss_ptr_q;
            end else begin
                if (req_accept) begin
                    fpc_q     <= fpc_q + XLEN'(4);
                    iss_ptr_q <= iss_ptr_q + PW'(1);
                end
                if (rsp_drop) begin
                    drop_q <= drop_q - PW'(1);
                end
                if (rsp_push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // The PC is written into the reserved slot when the request is issued.
    // The data lands in the same slot when the response returns. Live
    // responses come back in issue order, so wr_ptr always trails iss_ptr
    // onto the matching slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (req_accept && !redirect_i) begin
                pc_q[iss_ptr_q[AW-1:0]] <= fpc_q;
            end
            if (rsp_push) begin
                data_q[wr_ptr_q[AW-1:0]] <= mem_rsp_data_i;
            end
        end
    end

    rsp_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mem_rsp_valid_i |-> (pending_q != '0)
    );

endmodule
